// File: rtl/sdram_access_ctrl.sv
// Post-initialization SDRAM access engine: single-word reads/writes with
// auto-precharge plus periodic auto-refresh, owning the pins once init is done.
module sdram_access_ctrl #(
   parameter int unsigned T_RCD      = 2,
   parameter int unsigned T_RP       = 2,
   parameter int unsigned T_WR       = 2,
   parameter int unsigned T_RFC      = 7,
   parameter int unsigned CAS_LAT    = 2,
   parameter int unsigned REF_PERIOD = 390
) (
   input  logic        iclk,
   input  logic        ireset_n,
   input  logic        iinit_fin,
   input  logic        ireq,
   input  logic        iwe,
   input  logic [23:0] iaddr,
   input  logic [15:0] iwdata,
   output logic        oready,
   output logic        odone,
   output logic [15:0] ordata,
   output logic        DRAM_CLK,
   output logic        DRAM_CKE,
   output logic [12:0] DRAM_ADDR,
   output logic [1:0]  DRAM_BA,
   output logic        DRAM_CS_N,
   output logic        DRAM_RAS_N,
   output logic        DRAM_CAS_N,
   output logic        DRAM_WE_N,
   output logic        DRAM_LDQM,
   output logic        DRAM_UDQM,
   inout  wire  [15:0] DRAM_DQ
);

   localparam int unsigned WAIT_W = 8;
   localparam int unsigned REF_W  = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

   localparam logic [3:0] CMD_NOP     = 4'b0111;
   localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
   localparam logic [3:0] CMD_READ    = 4'b0101;
   localparam logic [3:0] CMD_WRITE   = 4'b0100;
   localparam logic [3:0] CMD_REFRESH = 4'b0001;

   typedef enum logic [3:0] {
      WAIT_INIT, IDLE, REFRESH, RFC_WAIT, ACTIVATE,
      RCD_WAIT, READ, CAS_WAIT, WRITE, RECOVER
   } state_t;

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
   logic               ref_due_q, ref_due_d;
   logic               oready_q, oready_d;
   logic               odone_q, odone_d;
   logic [15:0]        ordata_q, ordata_d;
   logic [3:0]         cmd_q, cmd_d;
   logic [12:0]        addr_q, addr_d;
   logic [1:0]         ba_q, ba_d;
   logic [1:0]         dqm_q, dqm_d;
   logic               dq_oe_q, dq_oe_d;
   logic               we_q, we_d;
   logic [8:0]         col_q, col_d;
   logic [15:0]        wdata_q, wdata_d;

   // Next-state, refresh bookkeeping and registered pin command.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      ref_cnt_d = ref_cnt_q;
      ref_due_d = ref_due_q;
      odone_d   = 1'b0;
      ordata_d  = ordata_q;
      cmd_d     = CMD_NOP;
      addr_d    = addr_q;
      ba_d      = ba_q;
      dqm_d     = 2'b11;
      dq_oe_d   = 1'b0;
      we_d      = we_q;
      col_d     = col_q;
      wdata_d   = wdata_q;

      // Refresh timer idles at zero until the pins are ours.
      if (state_q == WAIT_INIT) begin
         ref_cnt_d = '0;
         ref_due_d = 1'b0;
      end else begin
         if (state_q == REFRESH) ref_due_d = 1'b0;
         if (ref_cnt_q == REF_W'(REF_PERIOD - 1)) begin
            ref_cnt_d = '0;
            ref_due_d = 1'b1;
         end else begin
            ref_cnt_d = ref_cnt_q + REF_W'(1);
         end
      end

      case (state_q)
         WAIT_INIT: if (iinit_fin) state_d = IDLE;
         IDLE: begin
            if (ref_due_q) begin
               state_d = REFRESH;
            end else if (oready_q && ireq) begin
               we_d    = iwe;
               col_d   = iaddr[8:0];
               wdata_d = iwdata;
               state_d = ACTIVATE;
            end
         end
         REFRESH: begin
            state_d = RFC_WAIT;
            wait_d  = WAIT_W'(T_RFC - 1);
         end
         RFC_WAIT: begin
            if (wait_q == '0) state_d = IDLE;
            else              wait_d  = wait_q - WAIT_W'(1);
         end
         ACTIVATE: begin
            if (T_RCD > 1) begin
               state_d = RCD_WAIT;
               wait_d  = WAIT_W'(T_RCD - 2);
            end else begin
               state_d = we_q ? WRITE : READ;
            end
         end
         RCD_WAIT: begin
            if (wait_q == '0) state_d = we_q ? WRITE : READ;
            else              wait_d  = wait_q - WAIT_W'(1);
         end
         READ: begin
            state_d = CAS_WAIT;
            wait_d  = WAIT_W'(CAS_LAT - 1);
         end
         CAS_WAIT: begin
            if (wait_q == '0) begin
               ordata_d = DRAM_DQ;
               odone_d  = 1'b1;
               state_d  = RECOVER;
               wait_d   = WAIT_W'(T_RP - 1);
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         WRITE: begin
            odone_d = 1'b1;
            state_d = RECOVER;
            wait_d  = WAIT_W'(T_WR + T_RP - 1);
         end
         RECOVER: begin
            if (wait_q == '0) state_d = IDLE;
            else              wait_d  = wait_q - WAIT_W'(1);
         end
         default: state_d = WAIT_INIT;
      endcase

      // Losing pin ownership aborts everything without completion.
      if (!iinit_fin) begin
         state_d  = WAIT_INIT;
         odone_d  = 1'b0;
         ordata_d = ordata_q;
      end

      // The command for the state being entered is registered onto the pins.
      case (state_d)
         ACTIVATE: begin
            cmd_d  = CMD_ACTIVE;
            ba_d   = iaddr[23:22];
            addr_d = iaddr[21:9];
         end
         READ: begin
            cmd_d  = CMD_READ;
            addr_d = {2'b00, 1'b1, 1'b0, col_q};
         end
         WRITE: begin
            cmd_d   = CMD_WRITE;
            addr_d  = {2'b00, 1'b1, 1'b0, col_q};
            dqm_d   = 2'b00;
            dq_oe_d = 1'b1;
         end
         REFRESH: cmd_d = CMD_REFRESH;
         default: cmd_d = CMD_NOP;
      endcase

      oready_d = (state_d == IDLE) && !ref_due_d;
   end

   // State and output registers.
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state_q   <= WAIT_INIT;
         wait_q    <= '0;
         ref_cnt_q <= '0;
         ref_due_q <= 1'b0;
         oready_q  <= 1'b0;
         odone_q   <= 1'b0;
         ordata_q  <= '0;
         cmd_q     <= CMD_NOP;
         addr_q    <= '0;
         ba_q      <= '0;
         dqm_q     <= 2'b11;
         dq_oe_q   <= 1'b0;
         we_q      <= 1'b0;
         col_q     <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         ref_cnt_q <= ref_cnt_d;
         ref_due_q <= ref_due_d;
         oready_q  <= oready_d;
         odone_q   <= odone_d;
         ordata_q  <= ordata_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         ba_q      <= ba_d;
         dqm_q     <= dqm_d;
         dq_oe_q   <= dq_oe_d;
         we_q      <= we_d;
         col_q     <= col_d;
         wdata_q   <= wdata_d;
      end
   end

   assign oready = oready_q;
   assign odone  = odone_q;
   assign ordata = ordata_q;

   // Pins float until the initializer hands over the bus.
   assign DRAM_CLK   = iinit_fin ? ~iclk     : 1'bz;
   assign DRAM_CKE   = iinit_fin ? 1'b1      : 1'bz;
   assign DRAM_CS_N  = iinit_fin ? cmd_q[3]  : 1'bz;
   assign DRAM_RAS_N = iinit_fin ? cmd_q[2]  : 1'bz;
   assign DRAM_CAS_N = iinit_fin ? cmd_q[1]  : 1'bz;
   assign DRAM_WE_N  = iinit_fin ? cmd_q[0]  : 1'bz;
   assign DRAM_ADDR  = iinit_fin ? addr_q    : 13'bz;
   assign DRAM_BA    = iinit_fin ? ba_q      : 2'bz;
   assign DRAM_LDQM  = iinit_fin ? dqm_q[0]  : 1'bz;
   assign DRAM_UDQM  = iinit_fin ? dqm_q[1]  : 1'bz;
   assign DRAM_DQ    = (iinit_fin && dq_oe_q) ? wdata_q : 16'bz;

endmodule

// File: tb/tb_sdram_access_ctrl.sv
// Directed bench for sdram_access_ctrl with a one-word SDRAM data model.
module tb_sdram_access_ctrl;

   localparam logic [3:0] C_NOP     = 4'b0111;
   localparam logic [3:0] C_ACTIVE  = 4'b0011;
   localparam logic [3:0] C_READ    = 4'b0101;
   localparam logic [3:0] C_WRITE   = 4'b0100;
   localparam logic [3:0] C_REFRESH = 4'b0001;

   logic        iclk = 1'b0;
   logic        ireset_n, iinit_fin, ireq, iwe;
   logic [23:0] iaddr;
   logic [15:0] iwdata;
   logic        oready, odone;
   logic [15:0] ordata;
   logic        DRAM_CLK, DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N;
   logic        DRAM_LDQM, DRAM_UDQM;
   logic [12:0] DRAM_ADDR;
   logic [1:0]  DRAM_BA;
   wire  [15:0] DRAM_DQ;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   sdram_access_ctrl dut (
      .iclk(iclk), .ireset_n(ireset_n), .iinit_fin(iinit_fin), .ireq(ireq),
      .iwe(iwe), .iaddr(iaddr), .iwdata(iwdata), .oready(oready), .odone(odone),
      .ordata(ordata), .DRAM_CLK(DRAM_CLK), .DRAM_CKE(DRAM_CKE),
      .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA), .DRAM_CS_N(DRAM_CS_N),
      .DRAM_RAS_N(DRAM_RAS_N), .DRAM_CAS_N(DRAM_CAS_N), .DRAM_WE_N(DRAM_WE_N),
      .DRAM_LDQM(DRAM_LDQM), .DRAM_UDQM(DRAM_UDQM), .DRAM_DQ(DRAM_DQ)
   );

   always #5 iclk = ~iclk;
   always @(posedge iclk) cyc <= cyc + 1;

   wire [3:0] pin_cmd = {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};

   // SDRAM data model: one storage word, read data driven in the cycle
   // CAS_LAT after the READ command.
   logic [15:0] mem   = 16'h0000;
   logic [1:0]  rd_sr = 2'b00;
   always @(posedge iclk) begin
      rd_sr <= {rd_sr[0], (iinit_fin === 1'b1) && (pin_cmd === C_READ)};
      if (pin_cmd === C_WRITE) mem <= DRAM_DQ;
   end
   assign DRAM_DQ = (rd_sr[1] && iinit_fin) ? mem : 16'bz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge iclk);
   endtask

   initial begin
      logic        zok, found, early, saw_done;
      int          n, k;
      int          rc[4];

      ireset_n = 1'b0; iinit_fin = 1'b0; ireq = 1'b0; iwe = 1'b0;
      iaddr = '0; iwdata = '0;
      repeat (3) step();

      // Reset state, pins floating
      chk("rst_oready", 32'(oready), 32'd0);
      chk("rst_odone", 32'(odone), 32'd0);
      chk("rst_ordata", 32'(ordata), 32'h0);
      zok = (DRAM_CS_N === 1'bz) && (DRAM_RAS_N === 1'bz) && (DRAM_CLK === 1'bz) &&
            (DRAM_DQ === 16'hzzzz);
      chk("rst_pins_hiz", 32'(zok), 32'd1);
      ireset_n = 1'b1;
      step();
      zok = (DRAM_CS_N === 1'bz) && (DRAM_CKE === 1'bz) && (DRAM_ADDR === 13'bz);
      chk("preinit_pins_hiz", 32'(zok), 32'd1);
      chk("preinit_oready", 32'(oready), 32'd0);

      // Init handover
      iinit_fin = 1'b1;
      step();
      chk("init_oready", 32'(oready), 32'd1);
      chk("init_cke", 32'(DRAM_CKE), 32'd1);
      chk("init_cmd_nop", 32'(pin_cmd), 32'(C_NOP));
      chk("init_dqm", 32'({DRAM_UDQM, DRAM_LDQM}), 32'b11);
      chk("init_clk_inv", 32'(DRAM_CLK), 32'd1);

      // Write 0xBEEF to bank 2, row 0x0D2E, column 0x1C3
      ireq = 1'b1; iwe = 1'b1; iaddr = 24'h9A5DC3; iwdata = 16'hBEEF;
      step(); ireq = 1'b0;                                   // cycle 1
      chk("wr_c1_cmd", 32'(pin_cmd), 32'(C_ACTIVE));
      chk("wr_c1_ba", 32'(DRAM_BA), 32'd2);
      chk("wr_c1_row", 32'(DRAM_ADDR), 32'h0D2E);
      chk("wr_c1_oready", 32'(oready), 32'd0);
      step();                                                // cycle 2
      chk("wr_c2_cmd", 32'(pin_cmd), 32'(C_NOP));
      step();                                                // cycle 3
      chk("wr_c3_cmd", 32'(pin_cmd), 32'(C_WRITE));
      chk("wr_c3_addr", 32'(DRAM_ADDR), 32'h05C3);
      chk("wr_c3_dq", 32'(DRAM_DQ), 32'hBEEF);
      chk("wr_c3_dqm", 32'({DRAM_UDQM, DRAM_LDQM}), 32'b00);
      chk("wr_c3_odone", 32'(odone), 32'd0);
      step();                                                // cycle 4
      chk("wr_c4_odone", 32'(odone), 32'd1);
      chk("wr_c4_cmd", 32'(pin_cmd), 32'(C_NOP));
      zok = (DRAM_DQ === 16'hzzzz);
      chk("wr_c4_dq_hiz", 32'(zok), 32'd1);
      step();                                                // cycle 5
      chk("wr_c5_odone", 32'(odone), 32'd0);
      step(); step();                                        // cycle 7
      chk("wr_c7_oready", 32'(oready), 32'd0);
      step();                                                // cycle 8
      chk("wr_c8_oready", 32'(oready), 32'd1);

      // Read back the same address
      ireq = 1'b1; iwe = 1'b0; iaddr = 24'h9A5DC3;
      step(); ireq = 1'b0;                                   // cycle 1
      chk("rd_c1_cmd", 32'(pin_cmd), 32'(C_ACTIVE));
      step(); step();                                        // cycle 3
      chk("rd_c3_cmd", 32'(pin_cmd), 32'(C_READ));
      chk("rd_c3_addr", 32'(DRAM_ADDR), 32'h05C3);
      chk("rd_c3_dqm", 32'({DRAM_UDQM, DRAM_LDQM}), 32'b11);
      step(); step();                                        // cycle 5
      chk("rd_c5_odone", 32'(odone), 32'd0);
      step();                                                // cycle 6
      chk("rd_c6_odone", 32'(odone), 32'd1);
      chk("rd_c6_ordata", 32'(ordata), 32'hBEEF);
      step();                                                // cycle 7
      chk("rd_c7_odone", 32'(odone), 32'd0);
      chk("rd_c7_oready", 32'(oready), 32'd0);
      step();                                                // cycle 8
      chk("rd_c8_oready", 32'(oready), 32'd1);

      // Refresh wins over a request arriving in the same cycle
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         step();
         if (oready == 1'b0) begin found = 1'b1; break; end
      end
      chk("ref_due_seen", 32'(found), 32'd1);
      ireq = 1'b1; iwe = 1'b1; iaddr = 24'h412345; iwdata = 16'h1234;
      step();
      chk("ref_first_cmd", 32'(pin_cmd), 32'(C_REFRESH));
      chk("ref_first_oready", 32'(oready), 32'd0);
      found = 1'b0; early = 1'b0; n = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (pin_cmd === C_ACTIVE) begin found = 1'b1; n = i; break; end
         if (oready && i < 8) early = 1'b1;
      end
      ireq = 1'b0;
      chk("ref_act_found", 32'(found), 32'd1);
      chk("ref_to_act_gap", 32'(n - 1), 32'd8);
      chk("ref_oready_early", 32'(early), 32'd0);
      chk("ref_act_row", 32'(DRAM_ADDR), 32'h0091);
      chk("ref_act_ba", 32'(DRAM_BA), 32'd1);
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (odone) saw_done = 1'b1;
         if (oready) break;
      end
      chk("ref_wr_done", 32'(saw_done), 32'd1);
      ireq = 1'b1; iwe = 1'b0; iaddr = 24'h412345;
      step(); ireq = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (odone) begin saw_done = 1'b1; break; end
      end
      chk("ref_rd_done", 32'(saw_done), 32'd1);
      chk("ref_rd_data", 32'(ordata), 32'h1234);

      // Long idle: three refreshes, 390 cycles apart
      for (int i = 0; i < 20; i++) begin
         if (oready) break;
         step();
      end
      k = 0;
      for (int i = 0; i < 3 * 390; i++) begin
         step();
         if (pin_cmd === C_REFRESH) begin
            if (k < 4) rc[k] = cyc;
            k++;
         end
      end
      chk("idle_ref_count", 32'(k), 32'd3);
      if (k >= 3) begin
         chk("idle_ref_gap1", 32'(rc[1] - rc[0]), 32'd390);
         chk("idle_ref_gap2", 32'(rc[2] - rc[1]), 32'd390);
      end

      // Lose pin ownership during CAS wait
      for (int i = 0; i < 20; i++) begin
         if (oready) break;
         step();
      end
      ireq = 1'b1; iwe = 1'b0; iaddr = 24'h9A5DC3;
      step(); ireq = 1'b0;                                   // cycle 1
      step(); step();                                        // cycle 3
      chk("abort_c3_cmd", 32'(pin_cmd), 32'(C_READ));
      step();                                                // cycle 4
      iinit_fin = 1'b0;
      step();                                                // cycle 5
      zok = (DRAM_CS_N === 1'bz) && (DRAM_WE_N === 1'bz) && (DRAM_DQ === 16'hzzzz);
      chk("abort_pins_hiz", 32'(zok), 32'd1);
      chk("abort_oready", 32'(oready), 32'd0);
      saw_done = odone;
      for (int i = 0; i < 4; i++) begin
         step();
         if (odone) saw_done = 1'b1;
      end
      chk("abort_no_odone", 32'(saw_done), 32'd0);
      chk("abort_ordata_held", 32'(ordata), 32'h1234);
      iinit_fin = 1'b1;
      step();
      chk("reinit_oready", 32'(oready), 32'd1);

      // Reset in the middle of a write
      ireq = 1'b1; iwe = 1'b1; iaddr = 24'h9A5DC3; iwdata = 16'hCAFE;
      step(); ireq = 1'b0;
      step(); step();                                        // cycle 3
      chk("rstw_c3_dq", 32'(DRAM_DQ), 32'hCAFE);
      ireset_n = 1'b0;
      #1;
      chk("rstw_oready", 32'(oready), 32'd0);
      chk("rstw_odone", 32'(odone), 32'd0);
      chk("rstw_ordata", 32'(ordata), 32'h0);
      chk("rstw_cmd", 32'(pin_cmd), 32'(C_NOP));
      chk("rstw_dqm", 32'({DRAM_UDQM, DRAM_LDQM}), 32'b11);
      zok = (DRAM_DQ === 16'hzzzz);
      chk("rstw_dq_hiz", 32'(zok), 32'd1);
      step();
      ireset_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
